// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch port and the load/store port.
// Optional build macro MEMARB_DATA_PRIORITY_EN: data port always wins a simultaneous request.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W   = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

`ifdef MEMARB_DATA_PRIORITY_EN
    localparam logic PRIO_DATA = 1'b1;
`else
    localparam logic PRIO_DATA = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    state_t           r_state;
    owner_t           r_owner;
    owner_t           r_last_owner;
    logic             r_is_write;
    logic [CNT_W-1:0] r_cnt;

    logic w_idle;
    logic w_any_req;
    logic w_pick_data;
    logic w_grant;
    logic w_resp;

    // Reset gates every strobe so a request held through reset waits for the first clean IDLE cycle.
    assign w_idle    = (r_state == ST_IDLE) && !reset;
    assign w_any_req = if_req || d_req;
    assign w_grant   = w_idle && w_any_req;

    // With both requesting, the port that did not own the previous transaction wins.
    assign w_pick_data = d_req && (!if_req || PRIO_DATA || (r_last_owner == OWN_FETCH));

    assign if_gnt    = w_grant && !w_pick_data;
    assign d_gnt     = w_grant && w_pick_data;
    assign mem_en    = w_grant;
    assign mem_we    = w_grant && w_pick_data && d_we;
    assign mem_addr  = !w_grant ? '0 : (w_pick_data ? d_addr : if_addr);
    assign mem_wdata = (w_grant && w_pick_data) ? d_wdata : '0;

    assign w_resp    = !reset && (r_state == ST_BUSY) && (r_cnt == LAT_CNT);
    assign if_rvalid = w_resp && (r_owner == OWN_FETCH);
    assign d_rvalid  = w_resp && (r_owner == OWN_DATA);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !r_is_write) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_owner      <= OWN_FETCH;
            r_last_owner <= OWN_DATA;
            r_is_write   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state      <= ST_BUSY;
                        r_cnt        <= CNT_W'(1);
                        r_owner      <= w_pick_data ? OWN_DATA : OWN_FETCH;
                        r_last_owner <= w_pick_data ? OWN_DATA : OWN_FETCH;
                        r_is_write   <= w_pick_data && d_we;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == LAT_CNT) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle-level transaction model plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

`ifdef MEMARB_DATA_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    // Transaction model: at most one pending response, due LAT cycles after its grant.
    initial begin
        bit          m_pend = 1'b0;
        bit          m_last = 1'b1;
        bit          m_rport = 1'b0;
        bit          m_rwr = 1'b0;
        int          m_rcyc = 0;
        bit          win_d;
        logic        e_ig, e_dg, e_en, e_we, e_irv, e_drv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_ird, e_drd;
        forever begin
            @(negedge clk);
            e_ig = 0; e_dg = 0; e_en = 0; e_we = 0; e_irv = 0; e_drv = 0;
            e_addr = '0; e_wd = '0; e_ird = '0; e_drd = '0;
            if (reset) begin
                m_pend = 1'b0;
                m_last = 1'b1;
            end else if (m_pend) begin
                if (cyc == m_rcyc) begin
                    m_pend = 1'b0;
                    if (m_rport) begin
                        e_drv = 1;
                        e_drd = m_rwr ? '0 : mem_rdata;
                    end else begin
                        e_irv = 1;
                        e_ird = mem_rdata;
                    end
                end
            end else if (if_req || d_req) begin
                win_d  = d_req && (!if_req || PRIO || !m_last);
                e_en   = 1;
                e_ig   = !win_d;
                e_dg   = win_d;
                e_we   = win_d && d_we;
                e_addr = win_d ? d_addr : if_addr;
                e_wd   = win_d ? d_wdata : '0;
                m_pend  = 1'b1;
                m_rcyc  = cyc + LAT;
                m_rport = win_d;
                m_rwr   = win_d && d_we;
                m_last  = win_d;
            end
            chk("m_if_gnt", if_gnt, e_ig);
            chk("m_d_gnt", d_gnt, e_dg);
            chk("m_mem_en", mem_en, e_en);
            chk("m_mem_we", mem_we, e_we);
            chk("m_mem_addr", mem_addr, e_addr);
            chk("m_mem_wdata", mem_wdata, e_wd);
            chk("m_if_rvalid", if_rvalid, e_irv);
            chk("m_if_rdata", if_rdata, e_ird);
            chk("m_d_rvalid", d_rvalid, e_drv);
            chk("m_d_rdata", d_rdata, e_drd);
            cyc++;
        end
    end

    logic [2:0] pat [16] = '{3'b100, 3'b010, 3'b011, 3'b110, 3'b111, 3'b110, 3'b000, 3'b101,
                             3'b111, 3'b011, 3'b110, 3'b100, 3'b110, 3'b010, 3'b111, 3'b001};

    initial begin
        bit exp_d;
        // Reset held with a fetch request pending: no grant may leak out.
        if_req  = 1'b1;
        if_addr = 32'h10;
        nxt; nxt; nxt;
        mid;
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_mem_en", mem_en, 0);

        // Single fetch read, LATENCY=2.
        nxt; reset = 1'b0; mem_rdata = 32'hDEADBEEF;
        mid;
        chk("t1_gnt", if_gnt, 1);
        chk("t1_en", mem_en, 1);
        chk("t1_addr", mem_addr, 32'h10);
        nxt; if_req = 1'b0;
        mid;
        chk("t1_busy_rv", if_rvalid, 0);
        nxt;
        mid;
        chk("t1_rvalid", if_rvalid, 1);
        chk("t1_rdata", if_rdata, 32'hDEADBEEF);
        nxt; if_req = 1'b1; if_addr = 32'h14;
        mid;
        chk("t1_next_gnt", if_gnt, 1);
        nxt; if_req = 1'b0;
        nxt; nxt;

        // Both held from fresh reset: alternating grants every LAT+1 cycles.
        nxt; reset = 1'b1;
        nxt;
        for (int k = 0; k < 12; k++) begin
            nxt;
            if (k == 0) begin
                reset = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
                if_addr = 32'h100; d_addr = 32'h200; d_wdata = 32'h55;
            end
            mem_rdata = 32'hB000_0000 + k;
            mid;
            exp_d = PRIO || (((k / 3) % 2) == 1);
            if (k % 3 == 0) begin
                chk("t2_if_gnt", if_gnt, !exp_d);
                chk("t2_d_gnt", d_gnt, exp_d);
            end else begin
                chk("t2_nognt", if_gnt | d_gnt, 0);
            end
            if (k % 3 == 2) begin
                chk("t2_rvalid", exp_d ? d_rvalid : if_rvalid, 1);
                chk("t2_rdata", exp_d ? d_rdata : if_rdata, 32'hB000_0000 + k);
            end
        end
        nxt; d_req = 1'b0;
        mid;
        chk("t2_fetch_after", if_gnt, 1);
        nxt; if_req = 1'b0;
        nxt;

        // Data write: write acknowledge carries zero data.
        nxt; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
        mem_rdata = 32'hCAFEF00D;
        mid;
        chk("t3_d_gnt", d_gnt, 1);
        chk("t3_mem_we", mem_we, 1);
        chk("t3_wdata", mem_wdata, 32'h12345678);
        chk("t3_addr", mem_addr, 32'h20);
        nxt; d_req = 1'b0; d_we = 1'b0;
        mid;
        chk("t3_busy_rv", d_rvalid, 0);
        nxt;
        mid;
        chk("t3_d_rvalid", d_rvalid, 1);
        chk("t3_d_rdata", d_rdata, 0);
        chk("t3_if_rvalid", if_rvalid, 0);

        // Fetch raised while busy waits, then is granted on the first IDLE cycle.
        nxt; d_req = 1'b1; d_addr = 32'h30; d_wdata = '0; mem_rdata = 32'h600DD00D;
        mid;
        chk("t4_d_gnt", d_gnt, 1);
        chk("t4_mem_we", mem_we, 0);
        nxt; d_req = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        mid;
        chk("t4_wait1", if_gnt, 0);
        nxt;
        mid;
        chk("t4_wait2", if_gnt, 0);
        chk("t4_d_rvalid", d_rvalid, 1);
        chk("t4_d_rdata", d_rdata, 32'h600DD00D);
        nxt;
        mid;
        chk("t4_if_gnt", if_gnt, 1);
        chk("t4_addr", mem_addr, 32'h40);
        nxt; if_req = 1'b0;
        nxt; nxt;

        // Reset right after a fetch grant drops the transaction and restores round-robin state.
        nxt; if_req = 1'b1; if_addr = 32'h50;
        mid;
        chk("t5_gnt", if_gnt, 1);
        nxt; if_req = 1'b0; reset = 1'b1;
        mid;
        chk("t5_rst_rv", if_rvalid, 0);
        nxt; reset = 1'b0; if_req = 1'b1; d_req = 1'b1; d_addr = 32'h60; if_addr = 32'h70;
        mid;
        chk("t5_dropped", if_rvalid, 0);
        chk("t5_first", PRIO ? d_gnt : if_gnt, 1);
        nxt; if_req = 1'b0; d_req = 1'b0;
        nxt; mem_rdata = 32'h0BADCAFE;
        mid;
        chk("t5_resp", PRIO ? d_rvalid : if_rvalid, 1);
        chk("t5_rdata", PRIO ? d_rdata : if_rdata, 32'h0BADCAFE);
        nxt;

        // Mixed request table, checked by the model alone.
        for (int i = 0; i < 16; i++) begin
            nxt;
            {if_req, d_req, d_we} = pat[i];
            if_addr   = 32'h1000 + i * 4;
            d_addr    = 32'h2000 + i * 4;
            d_wdata   = 32'h7700_0000 + i;
            mem_rdata = 32'hE000_0000 ^ i;
        end
        nxt; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        nxt; nxt; nxt;
        mid;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the CPU fetch port (pc-driven) and the load/store data port.
- Non-pipelined: one outstanding transaction at a time, with a fixed memory read latency.
- Two requester ports using req/gnt/rvalid handshakes; one memory master port.
- Sits between the cpu core and the unified memory, replacing direct imem hookup once loads/stores exist.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- LATENCY, 2, cycles from the mem_en sample edge to mem_rdata valid; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address; stable while if_req is high and if_gnt is low
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid this cycle
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  read data valid / write acknowledge
- d_rdata  out  DATA_W  read data; 0 on write acknowledge
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid LATENCY cycles after the mem_en cycle

Behaviour:
- States: IDLE and BUSY.
- Registers:
  - owner (FETCH/DATA)
  - last_owner
  - is_write
  - cnt, width $clog2(LATENCY+1)
- Reset: state=IDLE, cnt=0, last_owner=DATA, owner=FETCH.
- All gnt/rvalid/mem_en/mem_we outputs are 0 while reset is high, and on the first cycle after reset until a request is present.
- IDLE arbitration (combinational from req and state):
  - Only one req high: grant it.
  - Both high: round-robin; grant the port that is not last_owner.
- Grant cycle T:
  - Assert x_gnt=1 and mem_en=1.
  - mem_addr and mem_wdata come from the winner; mem_we = winner is data ? d_we : 0.
  - At the edge ending T: state<=BUSY, cnt<=1, owner and last_owner<=winner, is_write latched.
- No request in IDLE: mem_en=0, and mem_addr/mem_wdata/mem_we are driven 0.
- BUSY:
  - No gnt is asserted; requests wait.
  - cnt increments each edge.
  - In the cycle where cnt==LATENCY (cycle T+LATENCY), assert the owner's rvalid=1.
  - Owner's rdata = is_write ? 0 : mem_rdata, passed through combinationally.
  - At the edge ending that cycle: state<=IDLE.
- Non-owner rvalid is 0; rdata outputs are 0 whenever rvalid is 0.
- Throughput: one transaction per LATENCY+1 cycles. The earliest next grant is T+LATENCY+1.
- Requesters may deassert req or change addr/wdata after gnt; the arbiter needs no address hold after T.
- Reset during BUSY: the outstanding transaction is dropped, no rvalid is issued, and the state returns to the reset values.
- req asserted during reset: no grant until the first IDLE cycle with reset low.
- LATENCY=1: cnt==1 on the cycle directly after the grant, so the response comes in T+1.

Optional Feature:
- Macro MEMARB_DATA_PRIORITY_EN.
- Defined: fixed priority; with both req high in IDLE, data is always granted. last_owner is still updated but ignored.
- Undefined: round-robin as specified.
- All other behaviour is identical in both builds.

Test Plan:
- LATENCY=2, if_req=1, if_addr=0x10, d_req=0, memory returns 0xDEADBEEF:
  - if_gnt and mem_en high in cycle 0 with mem_addr=0x10.
  - if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 2.
  - Next grant possible in cycle 3.
- Both req high from a fresh reset:
  - Fetch is granted first, then data at T+3.
  - With both held continuously, grants alternate F,D,F,D; no port waits for more than one transaction.
- d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678:
  - mem_we=1, mem_wdata=0x12345678 in the grant cycle.
  - d_rvalid=1 with d_rdata=0 two cycles later; if_rvalid stays 0.
- Requests raised during BUSY: no gnt until state returns to IDLE; the held request is then granted immediately.
- reset pulsed in the cycle after a fetch grant:
  - No if_rvalid ever appears for that fetch.
  - With both req high afterwards, fetch wins first (last_owner reset to DATA).
- MEMARB_DATA_PRIORITY_EN defined, both req held high: data is granted every time and fetch never wins; on d_req deassert, fetch is granted in the next IDLE cycle.
